// File: rtl/piano_audio_pkg.sv
// rtl/piano_audio_pkg.sv - shared types and constants for the piano audio paths
//
// Purpose : capture FSM state encoding and serial ADC frame geometry, shared
//           by the microphone sampler and its SCLK generator.
// Ports   : none (package).
package piano_audio_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int FRAME_BITS = 16;
   localparam int DATA_BITS  = 12;
   localparam int LEAD_ZEROS = 4;

   // The ADC shifts out LEAD_ZEROS zero bits ahead of the data; any one
   // there means the frame was misaligned or corrupted.
   function automatic logic lead_bits_set(input logic [FRAME_BITS-1:0] frame);
      return |frame[FRAME_BITS-1 -: LEAD_ZEROS];
   endfunction

endpackage

// File: rtl/mic_sampler_if.sv
// rtl/mic_sampler_if.sv - sample stream handshake between sampler and consumer
//
// Purpose : carries each captured sample plus its status pulses.
// Signals : sample        12  last completed sample, unsigned
//           sample_valid   1  sample holds unconsumed data
//           sample_ready   1  consumer accepts when high with sample_valid
//           overrun        1  one-cycle pulse, unconsumed sample overwritten
//           frame_err      1  one-cycle pulse, a leading-zero bit read as 1
// Modports: master = sampler side, slave = consumer side.
interface mic_sampler_if;
   import piano_audio_pkg::*;

   logic [DATA_BITS-1:0] sample;
   logic                 sample_valid;
   logic                 sample_ready;
   logic                 overrun;
   logic                 frame_err;

   modport master (
      output sample,
      output sample_valid,
      output overrun,
      output frame_err,
      input  sample_ready
   );

   modport slave (
      input  sample,
      input  sample_valid,
      input  overrun,
      input  frame_err,
      output sample_ready
   );

endinterface

// File: rtl/sclk_gen.sv
// rtl/sclk_gen.sv - ADC serial clock generator for one 16-bit frame
//
// Purpose : produces 16 SCLK periods of 2*CLK_DIV clk cycles, starting low.
// Ports   : clk, rst  system clock, synchronous active-high reset
//           start     one-cycle pulse on the cycle the FSM enters CONV
//           en        high while the FSM is in CONV
//           sclk      registered serial clock, idles high
//           rise      strobe on the cycle whose closing edge drives SCLK 0->1
//           done      strobe on the last cycle of the 16th high phase
module sclk_gen #(
   parameter int CLK_DIV = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic en,
   output logic sclk,
   output logic rise,
   output logic done
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic [4:0]    half_q, half_d;   // half-period index 0..31
   logic          sclk_q, sclk_d;
   logic          phase_end;

   assign phase_end = (cnt_q == CW'(CLK_DIV - 1));

   always_comb begin
      cnt_d  = cnt_q;
      half_d = half_q;
      sclk_d = sclk_q;
      rise   = 1'b0;
      done   = 1'b0;
      if (start) begin
         // SCLK drops together with CS so the first low phase is full length.
         cnt_d  = '0;
         half_d = '0;
         sclk_d = 1'b0;
      end else if (en) begin
         if (phase_end) begin
            cnt_d  = '0;
            half_d = half_q + 5'd1;
            if (half_q == 5'd31) begin
               // End of the 16th high phase: hold SCLK high into DONE.
               done   = 1'b1;
               sclk_d = 1'b1;
            end else begin
               sclk_d = ~sclk_q;
               rise   = ~sclk_q;
            end
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else begin
         cnt_d  = '0;
         half_d = '0;
         sclk_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         half_q <= '0;
         sclk_q <= 1'b1;
      end else begin
         cnt_q  <= cnt_d;
         half_q <= half_d;
         sclk_q <= sclk_d;
      end
   end

   assign sclk = sclk_q;

endmodule

// File: rtl/mic_sampler.sv
// rtl/mic_sampler.sv - microphone ADC capture front end with sample handshake
//
// Purpose : starts a conversion every SAMPLE_PERIOD clk cycles, clocks a
//           16-bit frame out of an ADCS7476-style ADC and presents the 12-bit
//           result on a valid/ready handshake with overrun and frame_err.
// Ports   : clk, rst  system clock, synchronous active-high reset
//           MISO      ADC serial data
//           CS        ADC chip select, active low
//           SCLK      ADC serial clock, idles high
//           smp       sample stream (master side of mic_sampler_if)
module mic_sampler
   import piano_audio_pkg::*;
#(
   parameter int CLK_DIV       = 3,
   parameter int SAMPLE_PERIOD = 2268
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            MISO,
   output logic            CS,
   output logic            SCLK,
   mic_sampler_if.master   smp
);

   if (CLK_DIV < 1 || SAMPLE_PERIOD < 32 * CLK_DIV + 2) begin : g_bad_params
      $error("mic_sampler: need CLK_DIV >= 1 and SAMPLE_PERIOD >= 32*CLK_DIV+2");
   end

   localparam int PW = $clog2(SAMPLE_PERIOD);

   logic [PW-1:0]         per_q, per_d;
   state_t                state_q, state_d;
   logic [FRAME_BITS-1:0] shift_q, shift_d;
   logic                  cs_q, cs_d;
   logic [DATA_BITS-1:0]  sample_q, sample_d;
   logic                  valid_q, valid_d;
   logic                  overrun_q, overrun_d;
   logic                  ferr_q, ferr_d;

   logic tick;
   logic start;
   logic load;
   logic sclk_rise;
   logic sclk_done;

   // Free-running period counter; its wrap cycle is the conversion tick.
   assign tick  = (per_q == PW'(SAMPLE_PERIOD - 1));
   assign per_d = tick ? '0 : per_q + 1'b1;

   always_comb begin
      state_d = state_q;
      start   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (tick) begin
               state_d = CONV;
               start   = 1'b1;
            end
         end
         CONV: begin
            if (sclk_done) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   sclk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sclk_gen (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .en    (state_q == CONV),
      .sclk  (SCLK),
      .rise  (sclk_rise),
      .done  (sclk_done)
   );

   assign load = (state_q == DONE);

   always_comb begin
      shift_d   = shift_q;
      if (sclk_rise) begin
         shift_d = {shift_q[FRAME_BITS-2:0], MISO};
      end
      // CS is decoded from the next state so it is registered yet aligned
      // with the state register.
      cs_d      = (state_d != CONV);
      sample_d  = load ? shift_q[DATA_BITS-1:0] : sample_q;
      // A load in the same cycle as an accept keeps valid set.
      valid_d   = load | (valid_q & ~smp.sample_ready);
      overrun_d = load & valid_q & ~smp.sample_ready;
      ferr_d    = load & lead_bits_set(shift_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         per_q     <= '0;
         state_q   <= IDLE;
         shift_q   <= '0;
         cs_q      <= 1'b1;
         sample_q  <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         per_q     <= per_d;
         state_q   <= state_d;
         shift_q   <= shift_d;
         cs_q      <= cs_d;
         sample_q  <= sample_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
         ferr_q    <= ferr_d;
      end
   end

   assign CS               = cs_q;
   assign smp.sample       = sample_q;
   assign smp.sample_valid = valid_q;
   assign smp.overrun      = overrun_q;
   assign smp.frame_err    = ferr_q;

endmodule

// File: tb/tb_mic_sampler.sv
// tb/tb_mic_sampler.sv - self-checking bench for mic_sampler
module tb_mic_sampler;

   typedef struct packed {
      logic [11:0] data;
      logic        ferr;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst   [2];
   logic        ready [2];
   logic        cs_a  [2];
   logic        sclk_a[2];
   logic [15:0] adc_mem [2][32];
   int          adc_n [2];

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, want);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : gen_dut
      localparam int CD = (g == 0) ? 2 : 1;
      localparam int SP = (g == 0) ? 100 : 34;

      mic_sampler_if smp_if ();
      logic        miso;
      logic [15:0] cur    = 16'h0;
      int          bitcnt = 16;
      int          rd     = 0;
      exp_t        exp_q[$];
      int          loads  = 0;

      assign smp_if.sample_ready = ready[g];

      mic_sampler #(
         .CLK_DIV       (CD),
         .SAMPLE_PERIOD (SP)
      ) dut (
         .clk  (clk),
         .rst  (rst[g]),
         .MISO (miso),
         .CS   (cs_a[g]),
         .SCLK (sclk_a[g]),
         .smp  (smp_if)
      );

      // ADC model: a new frame at each CS fall, one bit per SCLK rise.
      assign miso = (bitcnt < 16) ? cur[15 - bitcnt] : 1'b0;

      always @(negedge cs_a[g]) begin
         cur    = (rd < adc_n[g]) ? adc_mem[g][rd] : 16'h0;
         rd++;
         bitcnt = 0;
      end

      always @(posedge sclk_a[g]) begin
         if (cs_a[g] === 1'b0 && bitcnt < 16) begin
            bitcnt++;
            if (bitcnt == 16) exp_q.push_back('{cur[11:0], |cur[15:12]});
         end
      end

      // Monitor: timing checks plus a reference handshake model.
      int          cyc = 0, last_fall = 0, last_rise = 0, sclk_run = 0, rises = 0;
      logic        cs_prev = 1'b1, sclk_prev = 1'b1, first = 1'b1, done_flag = 1'b0;
      logic        ref_valid = 1'b0, exp_ovr, ref_ferr;
      logic [11:0] ref_sample = 12'h0;
      logic        r_rst, r_rdy;
      exp_t        e;

      always @(posedge clk) begin
         r_rst = rst[g];
         r_rdy = ready[g];
         #1;
         if (r_rst) begin
            cyc        = 0;
            first      = 1'b1;
            done_flag  = 1'b0;
            ref_valid  = 1'b0;
            ref_sample = 12'h0;
            exp_q.delete();
            check($sformatf("i%0d_rst_cs", g),     32'(cs_a[g]), 32'd1);
            check($sformatf("i%0d_rst_sclk", g),   32'(sclk_a[g]), 32'd1);
            check($sformatf("i%0d_rst_sample", g), 32'(smp_if.sample), 32'd0);
            check($sformatf("i%0d_rst_valid", g),  32'(smp_if.sample_valid), 32'd0);
            check($sformatf("i%0d_rst_ovr", g),    32'(smp_if.overrun), 32'd0);
            check($sformatf("i%0d_rst_ferr", g),   32'(smp_if.frame_err), 32'd0);
         end else begin
            cyc++;
            if (done_flag) begin
               e          = exp_q.pop_front();
               exp_ovr    = ref_valid && !r_rdy;
               ref_valid  = 1'b1;
               ref_sample = e.data;
               ref_ferr   = e.ferr;
               loads++;
            end else begin
               exp_ovr  = 1'b0;
               ref_ferr = 1'b0;
               if (ref_valid && r_rdy) ref_valid = 1'b0;
            end
            done_flag = 1'b0;
            check($sformatf("i%0d_valid@%0d", g, cyc), 32'(smp_if.sample_valid), 32'(ref_valid));
            check($sformatf("i%0d_ovr@%0d", g, cyc),   32'(smp_if.overrun), 32'(exp_ovr));
            check($sformatf("i%0d_ferr@%0d", g, cyc),  32'(smp_if.frame_err), 32'(ref_ferr));
            if (ref_valid)
               check($sformatf("i%0d_sample@%0d", g, cyc), 32'(smp_if.sample), 32'(ref_sample));

            if (cs_prev && !cs_a[g]) begin
               if (first) check($sformatf("i%0d_first_fall", g), cyc, SP);
               else begin
                  check($sformatf("i%0d_period", g), cyc - last_fall, SP);
                  check($sformatf("i%0d_cs_high", g), cyc - last_rise, SP - 32 * CD);
               end
               check($sformatf("i%0d_sclk_start", g), 32'(sclk_a[g]), 32'd0);
               first     = 1'b0;
               last_fall = cyc;
               sclk_run  = 1;
               rises     = 0;
            end else if (!cs_prev && cs_a[g]) begin
               check($sformatf("i%0d_cs_low", g), cyc - last_fall, 32 * CD);
               check($sformatf("i%0d_sclk_rises", g), rises, 16);
               check($sformatf("i%0d_sclk_last", g), sclk_run, CD);
               check($sformatf("i%0d_sclk_done", g), 32'(sclk_a[g]), 32'd1);
               last_rise = cyc;
               if (exp_q.size() > 0) done_flag = 1'b1;
            end else if (!cs_a[g]) begin
               if (sclk_a[g] != sclk_prev) begin
                  check($sformatf("i%0d_sclk_phase", g), sclk_run, CD);
                  if (sclk_a[g]) rises++;
                  sclk_run = 1;
               end else begin
                  sclk_run++;
               end
            end
         end
         cs_prev   = cs_a[g];
         sclk_prev = sclk_a[g];
      end
   end

   initial begin
      rst[0]   = 1'b1;
      rst[1]   = 1'b1;
      ready[0] = 1'b1;
      ready[1] = 1'b1;
      for (int i = 0; i < 32; i++) begin
         adc_mem[0][i] = 16'h0;
         adc_mem[1][i] = 16'h0;
      end
      adc_mem[0][0] = 16'h0ABC;
      adc_mem[0][1] = 16'h8123;
      adc_mem[0][2] = 16'h0111;
      adc_mem[0][3] = 16'h0222;
      adc_mem[0][4] = 16'h0333;
      adc_mem[0][5] = 16'h0FFF;   // aborted by reset mid-conversion
      adc_mem[0][6] = 16'h0456;
      adc_n[0]      = 7;
      for (int i = 0; i < 10; i++) adc_mem[1][i] = 16'($urandom);
      adc_n[1] = 10;

      repeat (3) @(negedge clk);
      rst[0] = 1'b0;
      rst[1] = 1'b0;                 // now in cycle 0
      repeat (280) @(negedge clk);
      ready[0] = 1'b0;               // cycle 280: hold off across two frames
      repeat (200) @(negedge clk);
      ready[0] = 1'b1;               // cycle 480
      repeat (152) @(negedge clk);
      rst[0] = 1'b1;                 // cycle 632: 32 cycles after CS fell at 600
      @(negedge clk);
      rst[0] = 1'b0;
      repeat (250) @(negedge clk);

      check("i0_loads", gen_dut[0].loads, 6);
      check("i0_exp_left", gen_dut[0].exp_q.size(), 0);
      check("i1_loads_min", 32'(gen_dut[1].loads >= 10), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
